// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared FSM state encoding and port-select constants for the RAM arbiter.
package ram_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester-side bus for the instruction-fetch (A) and load/store (B) ports.
interface ram_arbiter_if #(parameter int AW = 10);
  logic          a_req;
  logic [AW-1:0] a_addr;
  logic          a_ack;
  logic [31:0]   a_rdata;
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_wdata;
  logic          b_ack;
  logic [31:0]   b_rdata;
  modport master (output a_req, a_addr, b_req, b_we, b_addr, b_wdata,
                  input  a_ack, a_rdata, b_ack, b_rdata);
  modport slave  (input  a_req, a_addr, b_req, b_we, b_addr, b_wdata,
                  output a_ack, a_rdata, b_ack, b_rdata);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port arbiter serialising accesses to a single-port RAM, one access per 3 cycles.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int profundidad = 1024,
  localparam int AW = $clog2(profundidad)
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus,
  output logic [AW-1:0] ram_address,
  output logic [31:0]   ram_write_data,
  output logic          ram_MemWrite,
  output logic          ram_MemRead,
  input  logic [31:0]   ram_read_data
);
  state_t        state, state_nxt;
  logic          prio, sel, we_q, gnt;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q, a_rdata_q, b_rdata_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  always_comb begin
    gnt          = bus.b_req & (~bus.a_req | prio);
    state_nxt    = state == IDLE ? ((bus.a_req | bus.b_req) ? ACCESS : IDLE) :
                   state == ACCESS ? RESP : IDLE;
    ram_MemWrite = state == ACCESS && we_q;
    ram_MemRead  = state == ACCESS && !we_q;
    bus.a_ack    = state == RESP && sel == PORT_A;
    bus.b_ack    = state == RESP && sel == PORT_B;
  end
  // Request fields are captured once at grant so later input changes cannot disturb the access.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prio      <= PORT_A;
      sel       <= PORT_A;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (state == IDLE && (bus.a_req || bus.b_req)) begin
        sel     <= gnt;
        addr_q  <= gnt ? bus.b_addr : bus.a_addr;
        we_q    <= gnt & bus.b_we;
        wdata_q <= gnt ? bus.b_wdata : '0;
      end
      if (state == ACCESS && !we_q) begin
        if (sel == PORT_B) b_rdata_q <= ram_read_data;
        else               a_rdata_q <= ram_read_data;
      end
      if (state == RESP) prio <= ~sel;
    end
  assign bus.a_rdata    = a_rdata_q;
  assign bus.b_rdata    = b_rdata_q;
  assign ram_address    = addr_q;
  assign ram_write_data = wdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a behavioural RAM model.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  ram_address;
  logic [31:0] ram_write_data, ram_read_data;
  logic        ram_MemWrite, ram_MemRead;
  logic [31:0] mem [0:1023];
  int checks = 0;
  int failures = 0;
  ram_arbiter_if #(.AW(10)) bus ();
  ram_arbiter #(.profundidad(1024)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .ram_address(ram_address), .ram_write_data(ram_write_data),
    .ram_MemWrite(ram_MemWrite), .ram_MemRead(ram_MemRead),
    .ram_read_data(ram_read_data)
  );
  always #5 clk = ~clk;
  assign ram_read_data = mem[ram_address];
  always @(posedge clk) if (ram_MemWrite) mem[ram_address] <= ram_write_data;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[5] = 32'h0000_0013;
    mem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222;
    mem[3] = 32'hAAAA_0003;
    bus.a_req = 0; bus.a_addr = 0; bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
    tick; tick;
    check("rst_acks", {30'd0, bus.a_ack, bus.b_ack}, 0);
    check("rst_strobes", {30'd0, ram_MemWrite, ram_MemRead}, 0);
    check("rst_addr", {22'd0, ram_address}, 0);
    check("rst_wdata", ram_write_data, 0);
    check("rst_a_rdata", bus.a_rdata, 0);
    check("rst_b_rdata", bus.b_rdata, 0);
    rst_n = 1;
    bus.a_req = 1; bus.a_addr = 5;
    tick;
    check("a_acc_read", {30'd0, ram_MemWrite, ram_MemRead}, 32'd1);
    check("a_acc_addr", {22'd0, ram_address}, 5);
    check("a_acc_noack", {30'd0, bus.a_ack, bus.b_ack}, 0);
    tick;
    check("a_resp_acks", {30'd0, bus.a_ack, bus.b_ack}, 32'd2);
    check("a_resp_rdata", bus.a_rdata, 32'h0000_0013);
    bus.a_req = 0;
    tick;
    check("a_idle_acks", {30'd0, bus.a_ack, bus.b_ack}, 0);
    check("a_rdata_hold", bus.a_rdata, 32'h0000_0013);
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 8; bus.b_wdata = 32'hDEAD_BEEF;
    tick;
    check("bw_strobes", {30'd0, ram_MemWrite, ram_MemRead}, 32'd2);
    check("bw_addr", {22'd0, ram_address}, 8);
    check("bw_wdata", ram_write_data, 32'hDEAD_BEEF);
    tick;
    check("bw_resp_we", {31'd0, ram_MemWrite}, 0);
    check("bw_resp_acks", {30'd0, bus.a_ack, bus.b_ack}, 32'd1);
    check("bw_rdata_kept", bus.b_rdata, 0);
    bus.b_req = 0;
    tick;
    bus.b_req = 1; bus.b_we = 0;
    tick;
    check("br_strobes", {30'd0, ram_MemWrite, ram_MemRead}, 32'd1);
    tick;
    check("br_resp_acks", {30'd0, bus.a_ack, bus.b_ack}, 32'd1);
    check("br_rdata", bus.b_rdata, 32'hDEAD_BEEF);
    bus.b_req = 0;
    tick;
    bus.a_req = 1; bus.a_addr = 1; bus.b_req = 1; bus.b_addr = 2; bus.b_we = 0;
    for (int g = 0; g < 4; g++) begin
      tick;
      check("rr_access_noack", {30'd0, bus.a_ack, bus.b_ack}, 0);
      tick;
      check("rr_acks", {30'd0, bus.a_ack, bus.b_ack}, (g % 2 == 0) ? 32'd2 : 32'd1);
      if (g % 2 == 0) check("rr_a_rdata", bus.a_rdata, 32'h1111_1111);
      else            check("rr_b_rdata", bus.b_rdata, 32'h2222_2222);
      tick;
      check("rr_idle_noack", {30'd0, bus.a_ack, bus.b_ack}, 0);
    end
    bus.a_req = 0; bus.b_req = 0;
    tick;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 4; bus.b_wdata = 32'h4444_4444;
    tick;
    bus.b_addr = 9; bus.b_wdata = 32'h9999_9999;
    #1;
    check("chg_addr", {22'd0, ram_address}, 4);
    check("chg_wdata", ram_write_data, 32'h4444_4444);
    tick;
    bus.b_req = 0;
    tick;
    check("chg_mem4", mem[4], 32'h4444_4444);
    check("chg_mem9", mem[9], 0);
    bus.a_req = 1; bus.a_addr = 4;
    tick; tick;
    check("xport_ack", {30'd0, bus.a_ack, bus.b_ack}, 32'd2);
    check("xport_rdata", bus.a_rdata, 32'h4444_4444);
    bus.a_req = 0;
    tick;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 3; bus.b_wdata = 32'h1234_5678;
    tick;
    check("abort_pre_we", {31'd0, ram_MemWrite}, 32'd1);
    #2 rst_n = 0;
    #1;
    check("abort_we_drop", {30'd0, ram_MemWrite, ram_MemRead}, 0);
    check("abort_addr", {22'd0, ram_address}, 0);
    bus.b_req = 0;
    for (int c = 0; c < 3; c++) begin
      tick;
      check("abort_noack", {30'd0, bus.a_ack, bus.b_ack}, 0);
    end
    check("abort_mem3", mem[3], 32'hAAAA_0003);
    rst_n = 1;
    bus.a_req = 1; bus.a_addr = 5; bus.b_req = 1; bus.b_we = 0; bus.b_addr = 2;
    tick; tick;
    check("post_rst_prio", {30'd0, bus.a_ack, bus.b_ack}, 32'd2);
    check("post_rst_rdata", bus.a_rdata, 32'h0000_0013);
    bus.a_req = 0; bus.b_req = 0;
    tick;
    tick; tick;
    for (int c = 0; c < 10; c++) begin
      tick;
      check("idle_quiet", {28'd0, ram_MemWrite, ram_MemRead, bus.a_ack, bus.b_ack}, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: profundidad, 1024, RAM depth in 32-bit words; AW = ceil(log2(profundidad)) = 10 at default.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a_req  input  1  port A (instruction fetch, read-only) request.
REQ-005 a_addr  input  AW  port A word address.
REQ-006 a_ack  output  1  port A completion pulse, one cycle.
REQ-007 a_rdata  output  32  port A read data, valid while a_ack=1.
REQ-008 b_req  input  1  port B (load/store) request.
REQ-009 b_we  input  1  port B access type: 1 = write, 0 = read.
REQ-010 b_addr  input  AW  port B word address.
REQ-011 b_wdata  input  32  port B write data.
REQ-012 b_ack  output  1  port B completion pulse, one cycle.
REQ-013 b_rdata  output  32  port B read data, valid while b_ack=1 and access was a read.
REQ-014 ram_address  output  AW  address to RAM.
REQ-015 ram_write_data  output  32  write data to RAM.
REQ-016 ram_MemWrite  output  1  RAM write enable.
REQ-017 ram_MemRead  output  1  RAM read strobe.
REQ-018 ram_read_data  input  32  combinational RAM read data for ram_address.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when a_req|b_req; ACCESS->RESP always; RESP->IDLE always.
REQ-020 IDLE, no request: remain IDLE; ram_MemWrite=0, ram_MemRead=0.
REQ-021 IDLE, one request: grant that port; latch its addr, we (A: 0), wdata into registers.
REQ-022 IDLE, both requests: grant the port named by 1-bit priority pointer prio (0=A, 1=B).
REQ-023 prio set to the non-granted port on every RESP cycle (round-robin); neither port waits more than one foreign access.
REQ-024 ACCESS: ram_address = latched addr; ram_MemWrite = latched we for exactly this cycle; ram_MemRead = not latched we; ram_read_data captured into response register at cycle end when read.
REQ-025 RESP: assert ack of granted port for exactly one cycle; other ack stays 0; rdata drives captured word.
REQ-026 Latency: request sampled in IDLE at edge N -> ack high in cycle N+2; throughput one access per 3 cycles.
REQ-027 Requester holds req, addr, we, wdata stable until ack; drops req in the cycle after ack; req still high in next IDLE is a new request.
REQ-028 Inputs changing while not in IDLE have no effect on the current access (latched values used).
REQ-029 a_rdata/b_rdata hold last captured value when ack=0; port B write leaves b_rdata unchanged.
REQ-030 Write followed by read of same address from either port returns the written data (no bypass needed, accesses are serialised).
REQ-031 ram_MemWrite never asserted outside ACCESS.

Reset
REQ-032 rst_n=0 forces asynchronously: state IDLE, prio=0, a_ack=b_ack=0, ram_MemWrite=ram_MemRead=0, ram_address=0, ram_write_data=0, a_rdata=b_rdata=0.
REQ-033 Reset during ACCESS aborts the access; no write completes after rst_n falls; no ack is issued for the aborted request.
REQ-034 First grant after reset release uses edge sampling in IDLE; pending requests are re-arbitrated with prio=0.

Structure
REQ-035 Shared package ram_arbiter_pkg holds state enum (IDLE, ACCESS, RESP) and port-select constants PORT_A=0, PORT_B=1.
REQ-036 Single module; RAM instantiated outside; integration top connects ram_* to RAM address/write_data/MemWrite/MemRead/read_data.

Verification
REQ-037 Reset release, a_req=1, a_addr=5, RAM[5]=0x00000013 -> a_ack pulse 2 cycles after sampling, a_rdata=0x00000013, b_ack=0.
REQ-038 b_req=1, b_we=1, b_addr=8, b_wdata=0xDEADBEEF -> ram_MemWrite high one cycle with ram_address=8; then b read addr 8 -> b_rdata=0xDEADBEEF.
REQ-039 a_req and b_req held high continuously, addrs 1 and 2 -> acks alternate A,B,A,B every 3 cycles; no port acked twice consecutively.
REQ-040 Reset asserted in ACCESS of b write 0x12345678 to addr 3 -> ram_MemWrite drops immediately, no b_ack, RAM[3] unchanged.
REQ-041 b_addr changed from 4 to 9 during ACCESS -> ram_address stays 4, write lands at 4.
REQ-042 Both idle 10 cycles -> ram_MemWrite=ram_MemRead=0, acks 0 throughout.
